serial_frame_tx: RTL and testbench
==================================

// Module: serial_frame_tx
//
// PURPOSE
//  Serial frame transmitter: the driving end of the one-bit serial line "x" consumed by the
//  course's Mealy sequence detectors/receivers.
//  Accepts a parallel word over a valid/ready handshake and emits it on x as a framed bit stream:
//  start, data LSB-first, optional parity, stop. Each bit is held for BIT_CYC clocks.
//  Sits between a parallel producer (test sequencer / vending controller) and the serial line.
//
// PARAMETERS
//  DATA_W      8   data bits per frame (1..16)
//  BIT_CYC     4   clocks each line bit is held (>=1)
//  PARITY_EN   1   1 = insert parity bit after data; 0 = no parity bit
//  PARITY_ODD  0   0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
//
// PORTS
//  ck         in   1       clock; all state changes on rising edge
//  reset      in   1       synchronous, active-high reset
//  din        in   DATA_W  word to send; sampled only on accept
//  din_valid  in   1       producer has a word
//  din_ready  out  1       block can accept; accept = din_valid & din_ready at rising edge
//  x          out  1       serial line; idle level 0
//  busy       out  1       1 while a frame is in progress (state != IDLE)
//  done       out  1       one-cycle pulse when a frame completes
//
// BEHAVIOUR
//  - Reset is synchronous and active-high. At the edge with reset=1:
//    state=IDLE, x=0, done=0, counters=0, shift register=0.
//  - Line levels: idle 0, start bit 1, stop bit 0. Data bits are sent LSB first.
//  - Parity bit = ^data_latched ^ PARITY_ODD.
//  - State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//    - IDLE: x=0. din_ready = (state==IDLE) & ~reset. On accept, latch din and go to START.
//    - START, DATA, PARITY, STOP: each line bit is held exactly BIT_CYC cycles.
//      A bit timer ticks on the last cycle of each bit.
//    - DATA: bit index counts 0..DATA_W-1. The shift register shifts right on each tick.
//    - After data: go to PARITY if PARITY_EN=1, otherwise go straight to STOP.
//    - STOP: on its tick, go to IDLE.
//  - Output timing: x is registered.
//    - The start bit appears on x in the cycle after the accept edge.
//    - Frame length on x is F = (2 + DATA_W + PARITY_EN) * BIT_CYC cycles.
//  - done: registered pulse, high for the single cycle in which the state first returns to IDLE.
//  - busy: high for all F cycles of a frame.
//  - Back-to-back frames: a new accept is allowed in the same cycle that done=1 (state is IDLE).
//    The next start bit then follows the stop bit with no idle gap.
//  - While busy: din_ready=0. din_valid and din are ignored, and changes to din do not affect the
//    frame in flight (the word is latched).
//  - Reset mid-frame: the frame is aborted. Next cycle x=0, done stays 0, state=IDLE, and the
//    partial word is discarded.
//  - BIT_CYC=1 must work (one bit per clock, the timer ticks every cycle).
//  - DATA_W=1 must work.
//  - Simultaneous reset and accept: reset wins. Nothing is latched and din_ready reads 0 that cycle.
//
// STRUCTURE
//  - Package serial_pkg:
//    - state typedef {IDLE, START, DATA, PARITY, STOP}
//    - constants LINE_IDLE=1'b0, LINE_START=1'b1, LINE_STOP=1'b0
//    - these are shared with the matching receiver
//  - Sub-module bit_timer #(BIT_CYC)
//    - ports: ck, reset, clr, tick
//    - clr reloads the count; tick asserts on the BIT_CYC-th cycle after clr
//  - Top holds: FSM, DATA_W shift register, bit index counter, parity accumulator, output registers.
//
// TESTING
//  All tests use DATA_W=8, BIT_CYC=2, PARITY_EN=1, PARITY_ODD=0 unless stated otherwise.
//  1. Reset sequence:
//     - reset=1 for 2 cycles -> x=0, busy=0, done=0.
//     - After release -> din_ready=1.
//  2. Single frame: din=8'hA5, valid for 1 cycle ->
//     - x bit sequence = 1 | 1,0,1,0,0,1,0,1 | 0 | 0, each bit held 2 cycles (22 cycles total).
//     - done pulses once at cycle 23 after the accept edge.
//  3. Back-to-back: din=8'h01, then din=8'hFF offered in the done cycle ->
//     - Second start bit immediately follows the first frame's stop bit.
//     - Second frame's parity bit = 0 (8'hFF has 8 ones, so even parity gives 0).
//  4. Busy ignore:
//     - Assert din_valid with din=8'h3C mid-frame -> din_ready=0 and the frame in flight is unchanged.
//     - din=8'h3C is accepted only after done.
//  5. Reset mid-frame: assert reset during data bit 3 ->
//     - x=0 and busy=0 on the next cycle, no done pulse.
//     - A new frame with din=8'h80 then sends correctly.
//  6. Corner configurations: BIT_CYC=1, PARITY_EN=0, DATA_W=4, din=4'b1001 ->
//     - x = 1,1,0,0,1,0 on consecutive cycles; done pulses on the 7th cycle.

Source files
------------

// File: rtl/serial_pkg.sv
// Package: serial_pkg
//
// Shared definitions for the serial frame transmitter and its matching
// receiver: the frame state encoding and the line levels used on the
// one-bit serial line "x".
`timescale 1ns/1ps

package serial_pkg;

  // Frame states, in the order a frame walks through them.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } serial_state_t;

  // Line levels. Idle and stop are both 0, so a start bit (1) is the only
  // rising edge a receiver needs to look for.
  localparam logic LINE_IDLE  = 1'b0;
  localparam logic LINE_START = 1'b1;
  localparam logic LINE_STOP  = 1'b0;

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Module: bit_timer
//
// Counts out the duration of one line bit. While clr is high the count is
// held at zero; once clr drops, tick is high on the BIT_CYC-th cycle and the
// count then wraps, so tick repeats every BIT_CYC cycles.
//
// Ports:
//   ck    in  1  clock, rising edge
//   reset in  1  synchronous, active-high reset
//   clr   in  1  reload the count to zero
//   tick  out 1  high on the last cycle of each bit period
`timescale 1ns/1ps

module bit_timer #(
  parameter int BIT_CYC = 4
) (
  input  logic ck,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int               CNT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BIT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Wrapping on LAST makes the timer free-run across consecutive bits, so
  // the FSM only needs to clear it while idle. With BIT_CYC=1, LAST is 0 and
  // tick is high on every cycle.
  always_ff @(posedge ck) begin
    if (reset || clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// Module: serial_frame_tx
//
// Serial frame transmitter. Takes a parallel word over a valid/ready
// handshake and sends it on the one-bit line x as
// start(1), data LSB first, optional parity, stop(0).
// Each line bit is held for BIT_CYC clocks.
//
// Ports:
//   ck        in  1       clock, rising edge
//   reset     in  1       synchronous, active-high reset
//   din       in  DATA_W  word to send, sampled only on accept
//   din_valid in  1       producer has a word
//   din_ready out 1       idle and not in reset; accept = din_valid & din_ready
//   x         out 1       registered serial line, idles at 0
//   busy      out 1       high while a frame is in progress
//   done      out 1       one-cycle pulse as the FSM returns to IDLE
`timescale 1ns/1ps

module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BIT_CYC    = 4,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              ck,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              x,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  serial_state_t     state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt, shreg_shifted;
  logic [IDX_W-1:0]  bit_idx, bit_idx_nxt;
  logic              par, par_nxt;
  logic              x_q, x_nxt;
  logic              done_q, done_nxt;
  logic              tick, timer_clr, accept, last_bit;

  // Reset is part of din_ready so that a simultaneous reset and valid never
  // counts as an accept.
  assign din_ready     = (state == IDLE) && !reset;
  assign accept        = din_valid && din_ready;
  assign busy          = (state != IDLE);
  assign x             = x_q;
  assign done          = done_q;
  assign shreg_shifted = shreg >> 1;
  assign last_bit      = (bit_idx == IDX_W'(DATA_W - 1));
  assign timer_clr     = (state == IDLE);

  bit_timer #(
    .BIT_CYC (BIT_CYC)
  ) u_bit_timer (
    .ck    (ck),
    .reset (reset),
    .clr   (timer_clr),
    .tick  (tick)
  );

  // State and output registers.
  always_ff @(posedge ck) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      par     <= 1'b0;
      x_q     <= LINE_IDLE;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_idx <= bit_idx_nxt;
      par     <= par_nxt;
      x_q     <= x_nxt;
      done_q  <= done_nxt;
    end
  end

  // Next state and next line level. x is registered, so each branch
  // computes the level of the bit about to start: the new bit is on the
  // line in the first cycle of its state. The parity accumulator starts at
  // PARITY_ODD and folds in each data bit as it leaves the shift register.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_idx_nxt = bit_idx;
    par_nxt     = par;
    x_nxt       = x_q;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        x_nxt = LINE_IDLE;
        if (accept) begin
          state_nxt   = START;
          shreg_nxt   = din;
          bit_idx_nxt = '0;
          par_nxt     = 1'(PARITY_ODD);
          x_nxt       = LINE_START;
        end
      end

      START: begin
        if (tick) begin
          state_nxt = DATA;
          x_nxt     = shreg[0];
        end
      end

      DATA: begin
        if (tick) begin
          par_nxt   = par ^ shreg[0];
          shreg_nxt = shreg_shifted;
          if (last_bit) begin
            bit_idx_nxt = '0;
            if (PARITY_EN != 0) begin
              state_nxt = PARITY;
              x_nxt     = par ^ shreg[0];
            end else begin
              state_nxt = STOP;
              x_nxt     = LINE_STOP;
            end
          end else begin
            bit_idx_nxt = bit_idx + IDX_W'(1);
            x_nxt       = shreg_shifted[0];
          end
        end
      end

      PARITY: begin
        if (tick) begin
          state_nxt = STOP;
          x_nxt     = LINE_STOP;
        end
      end

      STOP: begin
        if (tick) begin
          state_nxt = IDLE;
          x_nxt     = LINE_IDLE;
          done_nxt  = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        x_nxt     = LINE_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Testbench: tb_serial_frame_tx
//
// Two instances: the default configuration (DATA_W=8, BIT_CYC=2, PARITY_EN=1,
// even parity) and a corner configuration (DATA_W=4, BIT_CYC=1, no parity).
// Inputs change and outputs are sampled just after the falling edge.
`timescale 1ns/1ps

module tb_serial_frame_tx;

  localparam int DW = 8;
  localparam int BC = 2;
  localparam int PE = 1;
  localparam int PO = 0;
  localparam int F  = (2 + DW + PE) * BC;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready, x, busy, done;

  logic [3:0] din_c;
  logic       valid_c;
  logic       ready_c, x_c, busy_c, done_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(
    .DATA_W(DW), .BIT_CYC(BC), .PARITY_EN(PE), .PARITY_ODD(PO)
  ) dut (
    .ck(clk), .reset(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .x(x), .busy(busy), .done(done)
  );

  serial_frame_tx #(
    .DATA_W(4), .BIT_CYC(1), .PARITY_EN(0), .PARITY_ODD(0)
  ) dut_c (
    .ck(clk), .reset(rst), .din(din_c), .din_valid(valid_c),
    .din_ready(ready_c), .x(x_c), .busy(busy_c), .done(done_c)
  );

  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] din;
    logic       ex;
    logic       ebusy;
    logic       edone;
    logic       eready;
  } vec_t;

  vec_t vecs[28];

  // Line level expected k cycles (k = 1..F) after the accept edge, worked
  // out from the frame layout: bit position = (k-1)/bit_cyc.
  function automatic logic model_x(input logic [15:0] w, input int dw,
                                   input int bc, input int pe, input int po,
                                   input int k);
    int pos;
    int ones;
    pos = (k - 1) / bc;
    if (pos == 0) return 1'b1;
    if (pos <= dw) return w[pos-1];
    if (pe != 0 && pos == dw + 1) begin
      ones = 0;
      for (int i = 0; i < dw; i++) ones += int'(w[i]);
      return ((ones + po) % 2) == 1;
    end
    return 1'b0;
  endfunction

  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d);
    rst       = r;
    din_valid = v;
    din       = d;
  endtask

  task automatic checkOutput(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, "_x"}, x, 1'b0);
    checkOutput({name, "_busy"}, busy, 1'b0);
    checkOutput({name, "_done"}, done, 1'b0);
    checkOutput({name, "_ready"}, din_ready, 1'b1);
  endtask

  // Called just after a falling edge with the DUT idle. Offers w, then
  // follows the whole frame and the done cycle, returning in the done cycle
  // so the caller may offer the next word back-to-back.
  // noise: 0 = valid low during the frame, 1 = valid held with nw,
  //        2 = random valid/din every cycle.
  task automatic sendAndCheck(input logic [7:0] w, input int noise, input logic [7:0] nw);
    applyStimulus(1'b0, 1'b1, w);
    #1;
    checkOutput("accept_ready", din_ready, 1'b1);
    for (int k = 1; k <= F; k++) begin
      @(negedge clk);
      #1;
      checkOutput("frame_x", x, model_x({8'h00, w}, DW, BC, PE, PO, k));
      checkOutput("frame_busy", busy, 1'b1);
      checkOutput("frame_done", done, 1'b0);
      checkOutput("frame_ready", din_ready, 1'b0);
      case (noise)
        1:       applyStimulus(1'b0, 1'b1, nw);
        2:       applyStimulus(1'b0, 1'($urandom), 8'($urandom));
        default: applyStimulus(1'b0, 1'b0, 8'($urandom));
      endcase
    end
    @(negedge clk);
    #1;
    checkOutput("end_done", done, 1'b1);
    checkOutput("end_busy", busy, 1'b0);
    checkOutput("end_x", x, 1'b0);
    checkOutput("end_ready", din_ready, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [10:0] a5_line;
    logic [5:0]  c_line;
    logic [7:0]  w;
    int          gap;

    // Frame for 8'hA5 by hand, bit 0 first on the line:
    // start 1, data 1,0,1,0,0,1,0,1, parity 0, stop 0.
    a5_line = 11'b00101001011;
    // Corner frame for 4'b1001: start 1, data 1,0,0,1, stop 0.
    c_line  = 6'b010011;

    vecs[0] = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 1; k <= 22; k++)
      vecs[3+k] = '{1'b0, 1'b0, 8'h5A, a5_line[(k-1)/2], 1'b1, 1'b0, 1'b0};
    vecs[26] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[27] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};

    valid_c = 1'b0;
    din_c   = 4'h0;
    applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset_x", x, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);

    // Reset/accept collision, release, then the hand-checked 8'hA5 frame.
    for (int i = 0; i < 28; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].din);
      #1;
      checkOutput($sformatf("vec%0d_x", i), x, vecs[i].ex);
      checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].ebusy);
      checkOutput($sformatf("vec%0d_done", i), done, vecs[i].edone);
      checkOutput($sformatf("vec%0d_ready", i), din_ready, vecs[i].eready);
      @(negedge clk);
    end

    // Back-to-back: 8'hFF offered in the done cycle of the 8'h01 frame.
    sendAndCheck(8'h01, 0, 8'h00);
    sendAndCheck(8'hFF, 0, 8'h00);
    @(negedge clk);
    #1;
    checkIdle("b2b_after");

    // 8'h3C held valid throughout a frame, accepted only after done.
    sendAndCheck(8'hC3, 1, 8'h3C);
    sendAndCheck(8'h3C, 0, 8'h00);
    @(negedge clk);
    #1;
    checkIdle("busy_after");

    // Reset during data bit 3 of 8'h5A (bit 3 is 1), starting at cycle 9.
    applyStimulus(1'b0, 1'b1, 8'h5A);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      #1;
      checkOutput("abort_x", x, model_x(16'h005A, DW, BC, PE, PO, k));
      applyStimulus(1'b0, 1'b0, 8'h00);
    end
    applyStimulus(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    checkOutput("abort_x0", x, 1'b0);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_done", done, 1'b0);
    checkOutput("abort_ready_in_reset", din_ready, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      checkIdle("abort_idle");
    end
    sendAndCheck(8'h80, 0, 8'h00);
    @(negedge clk);
    #1;

    // Corner configuration: one bit per clock, no parity, 4-bit data.
    valid_c = 1'b1;
    din_c   = 4'b1001;
    #1;
    checkOutput("c_ready", ready_c, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("c_x%0d", k), x_c, c_line[k-1]);
      checkOutput("c_busy", busy_c, 1'b1);
      checkOutput("c_done", done_c, 1'b0);
      valid_c = 1'b0;
      din_c   = 4'($urandom);
    end
    @(negedge clk);
    #1;
    checkOutput("c_done7", done_c, 1'b1);
    checkOutput("c_busy7", busy_c, 1'b0);
    checkOutput("c_x7", x_c, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("c_done8", done_c, 1'b0);

    // Random words, random gaps (0 = back-to-back) and random input noise.
    for (int n = 0; n < 30; n++) begin
      w   = 8'($urandom);
      gap = int'($urandom_range(0, 2));
      sendAndCheck(w, int'($urandom_range(0, 2)), 8'($urandom));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        #1;
        checkIdle("rand_gap");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
